// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock controller and its timers.
package clock_pkg;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_ALARM = 2'd1,
        MODE_SW    = 2'd2,
        MODE_CD    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_VIEW    = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/ring_timer.sv
// Tick-driven annunciator timer: trigger (re)loads RING_SECS, silence stops it early.
module ring_timer #(
    parameter int RING_SECS = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic trigger,
    input  logic silence,
    output logic active
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (trigger) begin
            // A fresh trigger beats a same-cycle silence so a new event is never lost.
            cnt    <= 8'(RING_SECS);
            active <= 1'b1;
        end else if (silence) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (tick && active) begin
            if (cnt <= 8'd1) begin
                cnt    <= '0;
                active <= 1'b0;
            end else begin
                cnt <= cnt - 8'd1;
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// Button-driven mode/edit sequencer for the clock datapath; owns alarm, stopwatch,
// countdown run control and the ring annunciator.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int SET_TIMEOUT = 10,
    parameter int RING_SECS   = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             btn_mode,
    input  logic             btn_set,
    input  logic             btn_inc,
    input  logic [HR_W-1:0]  cur_hr,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [SEC_W-1:0] cur_sec,
    input  logic             cd_done,
    output logic [1:0]       mode,
    output logic             editing,
    output logic             edit_field,
    output logic [HR_W-1:0]  edit_hr,
    output logic [MIN_W-1:0] edit_min,
    output logic             load_time,
    output logic             load_cd,
    output logic [HR_W-1:0]  alarm_hr,
    output logic [MIN_W-1:0] alarm_min,
    output logic             alarm_en,
    output logic             sw_run,
    output logic             sw_clear,
    output logic             cd_run,
    output logic             ring,
    output logic             blink
);

    state_t     state, state_nxt;
    logic [7:0] idle_cnt;
    logic       cd_loaded;
    logic       alarm_fired;
    logic       any_btn, b_set, b_mode, b_inc;
    logic       silence, timeout, alarm_match, alarm_hit, edit_nxt;

    // While ringing every press is swallowed by silencing.
    assign any_btn = btn_set | btn_mode | btn_inc;
    assign silence = ring & any_btn;
    assign b_set   = btn_set & ~ring;
    assign b_mode  = btn_mode & ~btn_set & ~ring;
    assign b_inc   = btn_inc & ~btn_set & ~btn_mode & ~ring;

    assign timeout     = tick_1hz & ~any_btn & (idle_cnt == 8'(SET_TIMEOUT - 1));
    assign alarm_match = (cur_hr == alarm_hr) && (cur_min == alarm_min);
    // alarm_fired makes the alarm fire once per matching minute, even if seconds stall at 0.
    assign alarm_hit   = alarm_en & tick_1hz & alarm_match & (cur_sec == '0) & ~alarm_fired;
    assign edit_nxt    = (state_nxt == ST_SET_HR) || (state_nxt == ST_SET_MIN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_VIEW:    if (b_set && mode != MODE_SW) state_nxt = ST_SET_HR;
            ST_SET_HR:  if (b_set) state_nxt = ST_SET_MIN; else if (timeout) state_nxt = ST_VIEW;
            ST_SET_MIN: if (b_set) state_nxt = ST_COMMIT;  else if (timeout) state_nxt = ST_VIEW;
            ST_COMMIT:  state_nxt = ST_VIEW;
            default:    state_nxt = ST_VIEW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_VIEW;
            mode        <= MODE_CLOCK;
            editing     <= 1'b0;
            edit_field  <= 1'b0;
            edit_hr     <= '0;
            edit_min    <= '0;
            load_time   <= 1'b0;
            load_cd     <= 1'b0;
            alarm_hr    <= '0;
            alarm_min   <= '0;
            alarm_en    <= 1'b0;
            sw_run      <= 1'b0;
            sw_clear    <= 1'b0;
            cd_run      <= 1'b0;
            blink       <= 1'b0;
            idle_cnt    <= '0;
            cd_loaded   <= 1'b0;
            alarm_fired <= 1'b0;
        end else begin
            state      <= state_nxt;
            editing    <= edit_nxt;
            edit_field <= (state_nxt == ST_SET_MIN);
            blink      <= edit_nxt ? (blink ^ tick_1hz) : 1'b0;
            load_time  <= 1'b0;
            load_cd    <= 1'b0;
            sw_clear   <= 1'b0;

            if (alarm_hit)         alarm_fired <= 1'b1;
            else if (!alarm_match) alarm_fired <= 1'b0;

            if (!edit_nxt)     idle_cnt <= '0;
            else if (any_btn)  idle_cnt <= '0;
            else if (tick_1hz) idle_cnt <= idle_cnt + 8'd1;

            unique case (state)
                ST_VIEW: begin
                    if (b_mode) begin
                        mode <= mode + 2'd1;
                    end else if (b_set) begin
                        case (mode)
                            MODE_CLOCK: begin edit_hr <= cur_hr;   edit_min <= cur_min;   end
                            MODE_ALARM: begin edit_hr <= alarm_hr; edit_min <= alarm_min; end
                            MODE_CD:    begin edit_hr <= '0;       edit_min <= '0;        end
                            default:    sw_run <= ~sw_run;
                        endcase
                    end else if (b_inc) begin
                        case (mode)
                            MODE_ALARM: alarm_en <= ~alarm_en;
                            MODE_SW:    if (!sw_run) sw_clear <= 1'b1;
                            MODE_CD:    if (cd_run || cd_loaded) cd_run <= ~cd_run;
                            default:    ;
                        endcase
                    end
                end
                ST_SET_HR, ST_SET_MIN: begin
                    if (timeout) begin
                        edit_hr  <= '0;
                        edit_min <= '0;
                    end else if (b_inc && state == ST_SET_HR) begin
                        edit_hr <= (edit_hr == HR_MAX) ? '0 : edit_hr + 5'd1;
                    end else if (b_inc) begin
                        edit_min <= (edit_min == MIN_MAX) ? '0 : edit_min + 6'd1;
                    end
                end
                ST_COMMIT: begin
                    case (mode)
                        MODE_CLOCK: load_time <= 1'b1;
                        MODE_ALARM: begin
                            alarm_hr  <= edit_hr;
                            alarm_min <= edit_min;
                            alarm_en  <= 1'b1;
                        end
                        MODE_CD: begin
                            load_cd   <= 1'b1;
                            cd_run    <= 1'b0;
                            cd_loaded <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase

            if (cd_done) cd_run <= 1'b0;
        end
    end

    ring_timer #(.RING_SECS(RING_SECS)) u_ring (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick_1hz),
        .trigger (alarm_hit | cd_done),
        .silence (silence),
        .active  (ring)
    );

endmodule
